div_seq_ctrl: RTL
=================

// Module: div_seq_ctrl
// PURPOSE
//  Sequencer between the CPU EX stage and the 32-iteration signed divider. Latches DIV operands,
//  issues a one-cycle start, tracks divider busy, waits for its registered q/r to settle, then
//  writes HI/LO. Stalls the pipeline meanwhile, serves MTHI/MTLO writes, flags divide-by-zero and hangs.
// PARAMETERS
//  SETTLE_CYCLES  1   cycles held after dv_busy falls before q/r are sampled (min 1)
//  WDOG_CYCLES    48  max cycles LAUNCH..RUN before abort with err (must exceed 34)
// PORTS
//  clock       in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-low reset
//  div_req     in   1   DIV issue, sampled only in IDLE
//  dividend    in   32  signed dividend, valid with div_req
//  divisor     in   32  signed divisor, valid with div_req
//  mthi        in   1   write HI from wdata (IDLE only)
//  mtlo        in   1   write LO from wdata (IDLE only)
//  wdata       in   32  MTHI/MTLO data
//  hi          out  32  HI register (remainder)
//  lo          out  32  LO register (quotient)
//  stall       out  1   pipeline hold
//  div_done    out  1   one-cycle pulse, cycle HI/LO take a division result
//  err         out  1   sticky: watchdog abort; cleared by next accepted div_req
//  dv_start    out  1   divider start pulse
//  dv_dividend out  32  divider operand, held from LAUNCH through CAPTURE
//  dv_divisor  out  32  divider operand, held from LAUNCH through CAPTURE
//  dv_busy     in   1   divider busy
//  dv_q        in   32  divider quotient
//  dv_r        in   32  divider remainder
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; hi=lo=0; stall=0; div_done=0; err=0; dv_start=0;
//   dv_dividend=dv_divisor=0; counters=0. Mid-operation reset aborts with no HI/LO write.
//  All outputs registered except stall = (state!=IDLE) | (state==IDLE & div_req & divisor!=0).
//  FSM: IDLE, LAUNCH, WAIT_BUSY, RUN, SETTLE, CAPTURE.
//  IDLE: div_req & divisor!=0 -> latch operands onto dv_*, clear err, -> LAUNCH.
//   div_req & divisor==0 -> same edge hi<=dividend, lo<=32'hFFFF_FFFF, div_done=1 next cycle; stay IDLE.
//   no div_req: mthi -> hi<=wdata, mtlo -> lo<=wdata (both allowed same cycle).
//   div_req beats mthi/mtlo in the same cycle; those writes are dropped.
//  LAUNCH: dv_start=1 exactly this cycle -> WAIT_BUSY.
//  WAIT_BUSY: dv_busy=1 -> RUN.
//  RUN: dv_busy=0 -> SETTLE; settle counter loaded with SETTLE_CYCLES.
//  SETTLE: count down; at 0 -> CAPTURE.
//  CAPTURE: at exit edge hi<=dv_r, lo<=dv_q, div_done=1 next cycle, -> IDLE.
//  Watchdog: cycle counter cleared on LAUNCH entry, counts in LAUNCH/WAIT_BUSY/RUN.
//   Reaching WDOG_CYCLES -> IDLE, err=1, HI/LO unchanged, no div_done.
//  Latency, SETTLE_CYCLES=1, divider busy 32 cycles: req sampled edge 0; dv_start cycle 1;
//   RUN from edge 3; dv_busy falls edge 34; HI/LO written edge 37; div_done high and stall low cycle 37.
//  div_req/mthi/mtlo outside IDLE are ignored (pipeline stalled); no state change.
//  dv_* operands never change while state!=IDLE. Divider sign fix-up reads them live.
//  No wrap: watchdog counter saturates; 6-bit minimum width.
// TESTING
//  100 / 7, req edge 0 -> dv_start one pulse cycle 1; lo=14, hi=2 and div_done at edge 37; stall 1..36.
//  -100 / 7 then 100 / -7 back-to-back, req held -> second accepted cycle 37; lo=0xFFFFFFF2 both, HI per divider model.
//  div_req, divisor=0, dividend=0x1234 -> next edge hi=0x1234, lo=0xFFFFFFFF, div_done 1 cycle, stall never high.
//  mthi+mtlo with wdata=0xA5A5A5A5 in IDLE -> hi=lo=0xA5A5A5A5; same cycle as div_req -> writes dropped.
//  Divider model holds dv_busy=0 forever -> err=1 after WDOG_CYCLES, IDLE, HI/LO unchanged; next req clears err.
//  reset low at cycle 20 of a division -> all outputs reset values immediately; no div_done after release.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// Sequencer between the EX stage and a 32-iteration signed divider.
// Latches DIV operands, pulses the divider start, follows its busy flag,
// lets q/r settle, then writes HI/LO. Also serves MTHI/MTLO, resolves
// divide-by-zero locally and aborts a hung divider via a watchdog.
module div_seq_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned WDOG_CYCLES   = 48
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_div_req,
   input  logic [31:0] i_dividend,
   input  logic [31:0] i_divisor,
   input  logic        i_mthi,
   input  logic        i_mtlo,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_stall,
   output logic        o_div_done,
   output logic        o_err,
   output logic        o_dv_start,
   output logic [31:0] o_dv_dividend,
   output logic [31:0] o_dv_divisor,
   input  logic        i_dv_busy,
   input  logic [31:0] i_dv_q,
   input  logic [31:0] i_dv_r
);

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned WDOG_RAW = $clog2(WDOG_CYCLES + 1);
   localparam int unsigned WDOG_W   = (WDOG_RAW < 6) ? 6 : WDOG_RAW;
   localparam int unsigned SET_RAW  = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned SET_W    = (SET_RAW < 1) ? 1 : SET_RAW;

   localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_CYCLES);
   localparam logic [WDOG_W-1:0] WDOG_MAX   = '1;
   localparam logic [SET_W-1:0]  SET_LOAD   = SET_W'(SETTLE_CYCLES);
   localparam logic [SET_W-1:0]  SET_ONE    = SET_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_RUN,
      S_SETTLE,
      S_CAPTURE
   } state_t;

   state_t             r_state;
   logic [WDOG_W-1:0]  r_wdog;
   logic [SET_W-1:0]   r_settle;
   logic [DATA_W-1:0]  r_hi;
   logic [DATA_W-1:0]  r_lo;
   logic               r_div_done;
   logic               r_err;
   logic               r_dv_start;
   logic [DATA_W-1:0]  r_dv_dividend;
   logic [DATA_W-1:0]  r_dv_divisor;

   logic               w_div_zero;
   logic               w_accept;
   logic [WDOG_W-1:0]  w_wdog_next;
   logic               w_wdog_trip;

   // Request decode and saturating watchdog increment
   assign w_div_zero  = (i_divisor == '0);
   assign w_accept    = (r_state == S_IDLE) & i_div_req & ~w_div_zero;
   assign w_wdog_next = (r_wdog == WDOG_MAX) ? r_wdog : r_wdog + WDOG_W'(1);
   assign w_wdog_trip = (w_wdog_next >= WDOG_LIMIT);

   // Stall is combinational so the pipeline holds in the same cycle a DIV is accepted
   assign o_stall = (r_state != S_IDLE) | w_accept;

   // Sequencer FSM with registered outputs and HI/LO ownership
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_wdog        <= '0;
         r_settle      <= '0;
         r_hi          <= '0;
         r_lo          <= '0;
         r_div_done    <= 1'b0;
         r_err         <= 1'b0;
         r_dv_start    <= 1'b0;
         r_dv_dividend <= '0;
         r_dv_divisor  <= '0;
      end else begin
         r_div_done <= 1'b0;
         r_dv_start <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_div_req) begin
                  if (w_div_zero) begin
                     r_hi       <= i_dividend;
                     r_lo       <= '1;
                     r_div_done <= 1'b1;
                  end else begin
                     r_dv_dividend <= i_dividend;
                     r_dv_divisor  <= i_divisor;
                     r_err         <= 1'b0;
                     r_wdog        <= '0;
                     r_state       <= S_LAUNCH;
                  end
               end else begin
                  if (i_mthi) r_hi <= i_wdata;
                  if (i_mtlo) r_lo <= i_wdata;
               end
            end
            S_LAUNCH: begin
               r_wdog <= w_wdog_next;
               if (w_wdog_trip) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else begin
                  r_dv_start <= 1'b1;
                  r_state    <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               r_wdog <= w_wdog_next;
               if (w_wdog_trip) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else if (i_dv_busy) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_wdog <= w_wdog_next;
               if (w_wdog_trip) begin
                  r_err   <= 1'b1;
                  r_state <= S_IDLE;
               end else if (!i_dv_busy) begin
                  r_settle <= SET_LOAD;
                  r_state  <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               // Holds for SETTLE_CYCLES cycles in total
               if (r_settle <= SET_ONE) begin
                  r_settle <= '0;
                  r_state  <= S_CAPTURE;
               end else begin
                  r_settle <= r_settle - SET_ONE;
               end
            end
            S_CAPTURE: begin
               r_hi       <= i_dv_r;
               r_lo       <= i_dv_q;
               r_div_done <= 1'b1;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_hi          = r_hi;
   assign o_lo          = r_lo;
   assign o_div_done    = r_div_done;
   assign o_err         = r_err;
   assign o_dv_start    = r_dv_start;
   assign o_dv_dividend = r_dv_dividend;
   assign o_dv_divisor  = r_dv_divisor;

endmodule
